cnn_iter_scheduler: RTL

CNN_ITER_SCHEDULER -- requirements
Module: cnn_iter_scheduler

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/cnn_iter_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the 4x4 CNN cell array.
//   WIDTH    : template/input word width; state words are 2*WIDTH
//   CELLS    : number of cells in the array (row-major 4x4)
//   CELL_W   : width of a cell index
//   PIPE_LAT : datapath latency from window issue to result capture
//   sched_state_t : iteration scheduler state encoding
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int WIDTH    = 9;
    localparam int CELLS    = 16;
    localparam int CELL_W   = $clog2(CELLS);
    localparam int PIPE_LAT = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_COMMIT = 3'd4,
        S_DONE   = 3'd5
    } sched_state_t;

endpackage

// File: rtl/cnn_iter_scheduler.sv
// -----------------------------------------------------------------------------
// cnn_iter_scheduler
// Sequences the CNN datapath through repeated sweeps of the 16 cells until
// either no cell's Y changed during a sweep (converged) or the iteration limit
// is reached. One sweep: 16 issue cycles (RUN), one drain cycle for the last
// capture (DRAIN), then COMMIT to start another sweep or DONE to finish.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : request a run (accepted in IDLE only)
//   abort           : cancel the run in progress, back to IDLE
//   max_iter        : iteration limit, latched on start (0 means 1)
//   y_new, y_old    : new and previous Y of the cell being captured
//   busy            : high in every state except IDLE
//   init_load       : pulse, datapath loads Initial_X into all X
//   cell_valid/idx  : cell whose window is presented this cycle
//   capture_en/idx  : cell whose result is written this cycle
//   commit          : pulse, copy next state into working state
//   done            : pulse, run finished
//   converged       : with done, the final sweep changed no Y; held to next start
//   iter_count      : completed iterations
// -----------------------------------------------------------------------------
module cnn_iter_scheduler #(
    parameter int WIDTH  = cnn_pkg::WIDTH,
    parameter int ITER_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [ITER_W-1:0]         max_iter,
    input  logic signed [2*WIDTH-1:0] y_new,
    input  logic signed [2*WIDTH-1:0] y_old,
    output logic                      busy,
    output logic                      init_load,
    output logic                      cell_valid,
    output logic [3:0]                cell_idx,
    output logic                      capture_en,
    output logic [3:0]                capture_idx,
    output logic                      commit,
    output logic                      done,
    output logic                      converged,
    output logic [ITER_W-1:0]         iter_count
);

    import cnn_pkg::*;

    localparam logic [3:0] LAST_CELL = 4'(CELLS - 1);

    sched_state_t      state;
    logic [ITER_W-1:0] limit;
    logic              changed;

    logic              y_diff;
    logic              changed_now;
    logic [ITER_W-1:0] iter_inc;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        y_diff      = (y_new != y_old);
        changed_now = changed;
        if (capture_en) begin
            // The first capture of a sweep restarts the flag.
            changed_now = (capture_idx == 4'd0) ? y_diff : (changed | y_diff);
        end
        iter_inc = (iter_count == '1) ? iter_count : iter_count + 1'b1;
    end

    // NOTE: state and registered outputs are written with non-blocking
    // assignments so every reader sees the pre-edge value within this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            limit       <= ITER_W'(1);
            changed     <= 1'b0;
            busy        <= 1'b0;
            init_load   <= 1'b0;
            cell_valid  <= 1'b0;
            cell_idx    <= 4'd0;
            capture_en  <= 1'b0;
            capture_idx <= 4'd0;
            commit      <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            iter_count  <= '0;
        end else begin
            // Pulses default low; the capture stage trails issue by PIPE_LAT=1.
            init_load   <= 1'b0;
            commit      <= 1'b0;
            done        <= 1'b0;
            capture_en  <= cell_valid;
            capture_idx <= cell_idx;
            changed     <= changed_now;

            if (abort && state != S_IDLE) begin
                // Abort beats every other transition; iter_count is kept.
                state      <= S_IDLE;
                busy       <= 1'b0;
                cell_valid <= 1'b0;
                capture_en <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            limit      <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                            iter_count <= '0;
                            converged  <= 1'b0;
                            busy       <= 1'b1;
                            init_load  <= 1'b1;
                            state      <= S_INIT;
                        end
                    end
                    S_INIT, S_COMMIT: begin
                        cell_valid <= 1'b1;
                        cell_idx   <= 4'd0;
                        state      <= S_RUN;
                    end
                    S_RUN: begin
                        if (cell_idx == LAST_CELL) begin
                            cell_valid <= 1'b0;
                            state      <= S_DRAIN;
                        end else begin
                            cell_idx <= cell_idx + 4'd1;
                        end
                    end
                    S_DRAIN: begin
                        // changed_now already folds in the cell-15 capture
                        // happening in this very cycle.
                        iter_count <= iter_inc;
                        if (!changed_now || iter_inc == limit) begin
                            done      <= 1'b1;
                            converged <= !changed_now;
                            state     <= S_DONE;
                        end else begin
                            commit <= 1'b1;
                            state  <= S_COMMIT;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy       <= 1'b0;
                        cell_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
